fifo_pack: RTL and testbench

FIFO_PACK -- requirements
Module: fifo_pack

---
 rtl/fifo_pkg.sv | 15 +
 rtl/ram.sv | 44 ++++
 rtl/fifo_pack.sv | 121 ++++++++++++
 tb/tb_fifo_pack.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the packing FIFO: default parameter values and the
// depth helper used by both the FIFO control logic and its storage.
package fifo_pkg;

    localparam int unsigned DEF_ADDR_SIZE = 6;
    localparam int unsigned DEF_DATA_SIZE = 32;
    localparam int unsigned DEF_NB_PACK   = 16;
    localparam int unsigned DEF_AF_MARGIN = 4;

    // Number of words addressable with addr_size pointer bits.
    function automatic int unsigned fifo_depth(input int unsigned addr_size);
        return 32'd1 << addr_size;
    endfunction

endpackage

// File: rtl/ram.sv
// Simple dual-port storage: synchronous write on port A, synchronous read
// on port B. The read register only loads when b_en is high, so the last
// read word is held; it clears on reset.
// Ports:
//   clk, nRST         clock, asynchronous active-low reset (read register only)
//   a_en/a_addr/a_data write port
//   b_en/b_addr/b_data read port (b_data valid the cycle after b_en)
module ram
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int unsigned DATA_SIZE = DEF_DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 a_en,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic [DATA_SIZE-1:0] a_data,
    input  logic                 b_en,
    input  logic [ADDR_SIZE-1:0] b_addr,
    output logic [DATA_SIZE-1:0] b_data
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_SIZE);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    // Write port; the array itself carries no reset.
    always_ff @(posedge clk) begin
        if (a_en) begin
            mem[a_addr] <= a_data;
        end
    end

    // Registered read port with hold.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            b_data <= '0;
        end else if (b_en) begin
            b_data <= mem[b_addr];
        end
    end

endmodule

// File: rtl/fifo_pack.sv
// Synchronous FIFO with burst-availability status. Storage lives in ram;
// pointers, occupancy, status flags and read handshake are kept here.
// Ports:
//   clk, nRST            clock, asynchronous active-low reset
//   data_in, w_e         write word and write request
//   r_en                 read request
//   data_out, r_valid    read word, valid one cycle after an accepted read
//   level                occupancy 0..2**ADDR_SIZE
//   empty, full, almost_full, nb_pack_available  flags decoded from level
// Optional (macro FIFO_ERR_FLAGS_EN):
//   err_clr              clears the sticky error flags
//   overflow, underflow  sticky: write while full / read while empty
module fifo_pack
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
    parameter int unsigned NB_PACK   = DEF_NB_PACK,
    parameter int unsigned AF_MARGIN = DEF_AF_MARGIN
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 w_e,
    input  logic                 r_en,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 r_valid,
    output logic [ADDR_SIZE:0]   level,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full,
    output logic                 nb_pack_available
`ifdef FIFO_ERR_FLAGS_EN
    ,
    input  logic                 err_clr,
    output logic                 overflow,
    output logic                 underflow
`endif
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_SIZE);
    localparam int unsigned LVL_W = ADDR_SIZE + 1;

    localparam logic [ADDR_SIZE:0] DEPTH_LVL = LVL_W'(DEPTH);
    localparam logic [ADDR_SIZE:0] AF_LVL    = LVL_W'(DEPTH - AF_MARGIN);
    localparam logic [ADDR_SIZE:0] PACK_LVL  = LVL_W'(NB_PACK);

    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic                 wr_acc_c;
    logic                 rd_acc_c;

    // Flags are pure decodes of the registered occupancy.
    assign empty             = (level == '0);
    assign full              = (level == DEPTH_LVL);
    assign almost_full       = (level >= AF_LVL);
    assign nb_pack_available = (level >= PACK_LVL);

    assign wr_acc_c = w_e & ~full;
    assign rd_acc_c = r_en & ~empty;

    // Pointers wrap naturally at ADDR_SIZE bits; level tracks net change.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= rd_acc_c;
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + ADDR_SIZE'(1);
            end
            if (rd_acc_c) begin
                rd_ptr <= rd_ptr + ADDR_SIZE'(1);
            end
            case ({wr_acc_c, rd_acc_c})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags; a new error in the same cycle beats err_clr.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_e && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (r_en && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`endif

    // Read port B loads only on accepted reads, so data_out holds otherwise.
    ram #(
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_SIZE (DATA_SIZE)
    ) u_ram (
        .clk    (clk),
        .nRST   (nRST),
        .a_en   (wr_acc_c),
        .a_addr (wr_ptr),
        .a_data (data_in),
        .b_en   (rd_acc_c),
        .b_addr (rd_ptr),
        .b_data (data_out)
    );

endmodule

// File: tb/tb_fifo_pack.sv
// Scoreboard bench for fifo_pack: a queue model tracks contents, the driver
// pushes expected read words at the accepting edge, and a monitor on the
// falling edge compares reads, occupancy and flags.
module tb_fifo_pack;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int PACK  = 16;
    localparam int AFM   = 4;

    logic          clk = 1'b0;
    logic          nRST;
    logic [DW-1:0] data_in;
    logic          w_e;
    logic          r_en;
    logic [DW-1:0] data_out;
    logic          r_valid;
    logic [AW:0]   level;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          nb_pack_available;
`ifdef FIFO_ERR_FLAGS_EN
    logic          err_clr;
    logic          overflow;
    logic          underflow;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_data;
    logic          m_ovf;
    logic          m_unf;

    always #5 clk = ~clk;

    fifo_pack dut (
        .clk               (clk),
        .nRST              (nRST),
        .data_in           (data_in),
        .w_e               (w_e),
        .r_en              (r_en),
        .data_out          (data_out),
        .r_valid           (r_valid),
        .level             (level),
        .empty             (empty),
        .full              (full),
        .almost_full       (almost_full),
        .nb_pack_available (nb_pack_available)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .err_clr           (err_clr),
        .overflow          (overflow),
        .underflow         (underflow)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; model updated at the edge that the DUT samples.
    task automatic cycle(input logic we, input logic re, input logic [DW-1:0] d, input logic clr);
        int  lvl;
        logic wacc;
        logic racc;
        w_e     = we;
        r_en    = re;
        data_in = d;
`ifdef FIFO_ERR_FLAGS_EN
        err_clr = clr;
`endif
        lvl  = model_q.size();
        wacc = we && (lvl != DEPTH);
        racc = re && (lvl != 0);
        @(posedge clk);
        if (racc) exp_q.push_back(model_q.pop_front());
        if (wacc) model_q.push_back(d);
        m_ovf = (we && lvl == DEPTH) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_unf = (re && lvl == 0)     ? 1'b1 : (clr ? 1'b0 : m_unf);
        #1;
        w_e  = 1'b0;
        r_en = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
    endtask

    task automatic drain();
        while (model_q.size() != 0) cycle(1'b0, 1'b1, '0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_level"}, 64'(level), 64'd0);
        chk({tag, "_empty"}, 64'(empty), 64'd1);
        chk({tag, "_full"}, 64'(full), 64'd0);
        chk({tag, "_af"}, 64'(almost_full), 64'd0);
        chk({tag, "_pack"}, 64'(nb_pack_available), 64'd0);
        chk({tag, "_rvalid"}, 64'(r_valid), 64'd0);
        chk({tag, "_dout"}, 64'(data_out), 64'd0);
    endtask

    // Monitor: read data against scoreboard, status against model occupancy.
    initial begin : monitor
        int lvl;
        forever begin
            @(negedge clk);
            if (nRST) begin
                if (r_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_rvalid: got data %0h expected no read", data_out);
                    end else begin
                        last_data = exp_q.pop_front();
                        chk("data_out", 64'(data_out), 64'(last_data));
                    end
                end else begin
                    if (exp_q.size() != 0) begin
                        chk("r_valid", 64'(r_valid), 64'd1);
                        void'(exp_q.pop_front());
                    end
                    chk("data_hold", 64'(data_out), 64'(last_data));
                end
                lvl = model_q.size();
                chk("level", 64'(level), 64'(lvl));
                chk("empty", 64'(empty), 64'(lvl == 0));
                chk("full", 64'(full), 64'(lvl == DEPTH));
                chk("almost_full", 64'(almost_full), 64'(lvl >= DEPTH - AFM));
                chk("nb_pack", 64'(nb_pack_available), 64'(lvl >= PACK));
`ifdef FIFO_ERR_FLAGS_EN
                chk("overflow", 64'(overflow), 64'(m_ovf));
                chk("underflow", 64'(underflow), 64'(m_unf));
`endif
            end
        end
    end

    initial begin : stim
        int pw;
        int pr;
        nRST      = 1'b0;
        w_e       = 1'b0;
        r_en      = 1'b0;
        data_in   = '0;
        last_data = '0;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
        err_clr   = 1'b0;
`endif
        #2;
        chk_reset_outputs("por");
        #10;
        nRST = 1'b1;

        // Burst threshold and in-order readback.
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0);
        chk("pack_at_20", 64'(nb_pack_available), 64'd1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, '0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, '0, 1'b0);

        // Fill to full, one extra write rejected, then drain.
        for (int i = 0; i < 65; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0);
        chk("full_after_65", 64'(full), 64'd1);
        drain();

        // Simultaneous read/write at depth-1.
        for (int i = 0; i < 63; i++) cycle(1'b1, 1'b0, DW'(100 + i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, DW'(500 + i), 1'b0);
        chk("level_63_rw", 64'(level), 64'd63);
        drain();

        // Read while empty, then clear error flags.
        cycle(1'b0, 1'b1, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // Pointer wrap.
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, DW'(1000 + i), 1'b0);
        drain();

        // Asynchronous reset mid-content.
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, DW'(2000 + i), 1'b0);
        cycle(1'b0, 1'b1, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        #1;
        nRST = 1'b0;
        #1;
        chk_reset_outputs("async");
        model_q.delete();
        exp_q.delete();
        last_data = '0;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
        nRST      = 1'b1;
        cycle(1'b1, 1'b0, 32'h0000_abcd, 1'b0);
        cycle(1'b0, 1'b1, '0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, '0, 1'b0);

        // Random traffic with phases biased toward full, empty and balance.
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0:       begin pw = 85; pr = 25; end
                1:       begin pw = 20; pr = 85; end
                2:       begin pw = 50; pr = 50; end
                default: begin pw = 95; pr = 90; end
            endcase
            for (int i = 0; i < 500; i++) begin
                cycle(($urandom_range(99) < pw), ($urandom_range(99) < pr), $urandom,
                      ($urandom_range(7) == 0));
            end
        end
        drain();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
